eeg_loader: RTL and testbench

- Ingests the raw 16-bit unsigned ADC EEG stream while the top-level CiM state is EEG_LOAD.
- Converts each sample to the double-width intermediate-result fixed-point format and buffers it in a small FIFO.
- Writes samples sequentially into intermediate-result memory starting at mem_map[EEG_INPUT_MEM].
- Sits between the ADC interface and the int-res memory write port; signals completion to the top-level FSM so it can enter INFERENCE_RUNNING.

---
 rtl/eeg_loader_pkg.sv | 31 +++
 rtl/eeg_loader_fifo.sv | 49 ++++
 rtl/eeg_loader.sv | 103 ++++++++++
 tb/tb_eeg_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_loader_pkg.sv
// Shared types and constants for the CiM intermediate-result datapath slice around the EEG loader.
package eeg_loader_pkg;

   localparam int ADC_BITWIDTH            = 16;
   localparam int Q_STO_INT_RES_DOUBLE    = 20;
   localparam int INT_RES_DOUBLE_BITWIDTH = 30;
   localparam int INT_RES_ADDR_BITWIDTH   = 16;
   localparam int NUM_PATCHES             = 60;
   localparam int PATCH_LEN               = 64;

   localparam int EEG_NUM_SAMPLES = NUM_PATCHES * PATCH_LEN;
   localparam int EEG_TO_FX_SHIFT = Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH;

   typedef logic [ADC_BITWIDTH-1:0]            AdcData_t;
   typedef logic [INT_RES_ADDR_BITWIDTH-1:0]   IntResAddr_t;
   typedef logic [INT_RES_DOUBLE_BITWIDTH-1:0] IntResDouble_t;

   typedef enum logic {SINGLE_WIDTH, DOUBLE_WIDTH} DataWidth_t;
   typedef enum logic [1:0] {INT_RES_SW_FX_1_X, INT_RES_SW_FX_2_X, INT_RES_DW_FX} FxFormatIntRes_t;
   typedef enum logic [1:0] {EEG_IDLE, EEG_LOADING, EEG_DRAINING, EEG_DONE} EegLoadState_t;

   localparam int              EEG_INPUT_MEM_BASE = 0;
   localparam DataWidth_t      EEG_WIDTH          = DOUBLE_WIDTH;
   localparam FxFormatIntRes_t EEG_FORMAT         = INT_RES_DW_FX;

   // ADC samples are unsigned fractions, so aligning the binary point is a plain left shift.
   function automatic IntResDouble_t adc_to_fx(input AdcData_t sample);
      return IntResDouble_t'({sample, {EEG_TO_FX_SHIFT{1'b0}}});
   endfunction

endpackage

// File: rtl/eeg_loader_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally whenever not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit separates full from empty when the index bits coincide.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/eeg_loader.sv
// Streams one window of ADC EEG samples into int-res memory in double-width fixed point.
module eeg_loader
   import eeg_loader_pkg::*;
#(
   parameter int NUM_SAMPLES = EEG_NUM_SAMPLES,
   parameter int FIFO_DEPTH  = 4,
   parameter int BASE_ADDR   = EEG_INPUT_MEM_BASE
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   input  logic                               adc_valid,
   input  logic [ADC_BITWIDTH-1:0]            adc_data,
   output logic                               adc_ready,
   output logic                               wr_en,
   output logic [INT_RES_ADDR_BITWIDTH-1:0]   wr_addr,
   output logic [INT_RES_DOUBLE_BITWIDTH-1:0] wr_data,
   output DataWidth_t                         wr_width,
   output FxFormatIntRes_t                    wr_format,
   input  logic                               wr_grant,
   output logic                               busy,
   output logic                               done
);

   localparam int               CNT_W    = $clog2(NUM_SAMPLES + 1);
   localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

   EegLoadState_t    state;
   EegLoadState_t    next_state;
   logic [CNT_W-1:0] accept_cnt;
   logic [CNT_W-1:0] write_cnt;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   IntResDouble_t    fifo_head;
   logic             last_accept;
   logic             last_write;

   assign adc_ready   = (state == EEG_LOADING) && !fifo_full && (accept_cnt < NUM_CNT);
   assign push        = adc_valid && adc_ready;
   assign wr_en       = !fifo_empty;
   assign pop         = wr_en && wr_grant;
   assign last_accept = push && (accept_cnt == LAST_CNT);
   assign last_write  = pop && (write_cnt == LAST_CNT);

   assign wr_addr   = IntResAddr_t'(BASE_ADDR) + IntResAddr_t'(write_cnt);
   assign wr_data   = wr_en ? fifo_head : '0;
   assign wr_width  = EEG_WIDTH;
   assign wr_format = EEG_FORMAT;

   sync_fifo #(
      .WIDTH (INT_RES_DOUBLE_BITWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .push  (push),
      .pop   (pop),
      .din   (adc_to_fx(adc_data)),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Counters clear on the final write so the idle address rests at BASE_ADDR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_cnt <= '0;
         write_cnt  <= '0;
      end else if (abort || last_write) begin
         accept_cnt <= '0;
         write_cnt  <= '0;
      end else begin
         if (push) accept_cnt <= accept_cnt + CNT_W'(1);
         if (pop)  write_cnt  <= write_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EEG_IDLE;
      else        state <= next_state;
   end

   // Transitions fire on the counting event itself, so done follows the final grant by one cycle.
   always_comb begin
      next_state = state;
      busy       = (state != EEG_IDLE);
      done       = (state == EEG_DONE);
      case (state)
         EEG_IDLE:     if (start) next_state = EEG_LOADING;
         EEG_LOADING:  if (last_accept) next_state = EEG_DRAINING;
         EEG_DRAINING: if (last_write) next_state = EEG_DONE;
         EEG_DONE:     next_state = EEG_IDLE;
         default:      next_state = EEG_IDLE;
      endcase
      if (abort) next_state = EEG_IDLE;
   end

endmodule

// File: tb/tb_eeg_loader.sv
// Scoreboard bench for eeg_loader: accepted samples queue expected writes, a monitor retires them.
module tb_eeg_loader;
   import eeg_loader_pkg::*;

   localparam int NUM = EEG_NUM_SAMPLES;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            start     = 1'b0;
   logic            abort     = 1'b0;
   logic            adc_valid = 1'b0;
   logic            wr_grant  = 1'b0;
   logic [15:0]     adc_data  = '0;
   logic            adc_ready;
   logic            wr_en;
   logic [15:0]     wr_addr;
   logic [29:0]     wr_data;
   DataWidth_t      wr_width;
   FxFormatIntRes_t wr_format;
   logic            busy;
   logic            done;

   typedef struct packed {
      logic [15:0] addr;
      logic [29:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_push;
   exp_t        mon_pop;
   int          checks = 0;
   int          fails = 0;
   int          exp_idx = 0;
   int          win_writes = 0;
   int          done_count = 0;
   int          cyc = 0;
   int          last_grant_cyc = 0;
   int          done_cyc = 0;
   logic [15:0] first_addr, second_addr, last_addr;
   logic [29:0] first_data, second_data;

   eeg_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .adc_valid (adc_valid),
      .adc_data  (adc_data),
      .adc_ready (adc_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_width  (wr_width),
      .wr_format (wr_format),
      .wr_grant  (wr_grant),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every handshake queues a hand-derived write; every granted write retires the oldest one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (adc_valid && adc_ready) begin
            mon_push.addr = 16'(exp_idx);
            mon_push.data = {10'b0, adc_data, 4'b0};
            exp_q.push_back(mon_push);
            exp_idx++;
         end
         if (wr_en && wr_grant) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_write: got write addr 0x%0h, expected no write", wr_addr);
            end else begin
               mon_pop = exp_q.pop_front();
               check("wr_addr", wr_addr, mon_pop.addr);
               check("wr_data", wr_data, mon_pop.data);
            end
            if (win_writes == 0) begin
               first_addr = wr_addr;
               first_data = wr_data;
            end else if (win_writes == 1) begin
               second_addr = wr_addr;
               second_data = wr_data;
            end
            last_addr = wr_addr;
            last_grant_cyc = cyc;
            win_writes++;
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_scoreboard();
      exp_q.delete();
      exp_idx    = 0;
      win_writes = 0;
      done_count = 0;
   endtask

   function automatic logic [15:0] pick(input int idx);
      if (idx == 0) return 16'h8000;
      if (idx == 1) return 16'hFFFF;
      return 16'($urandom);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_adc_ready"}, adc_ready, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // One full window; a stray start at n==20 must be ignored, optional 10-cycle grant stall.
   task automatic run_window(input int valid_pct, input int grant_pct, input int stall_cyc);
      bit finished;
      finished = 0;
      clear_scoreboard();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 20000 && !finished; n++) begin
         start     = (n == 20);
         adc_valid = (exp_idx < NUM) && ($urandom_range(99) < valid_pct);
         adc_data  = pick(exp_idx);
         wr_grant  = !(stall_cyc >= 0 && n >= stall_cyc && n < stall_cyc + 10)
                     && ($urandom_range(99) < grant_pct);
         settle();
         if (stall_cyc >= 0 && n == stall_cyc + 9) begin
            check("stall_adc_ready", adc_ready, 0);
            check("stall_fifo_level", exp_q.size(), 4);
            check("stall_wr_en", wr_en, 1);
            check("stall_wr_addr", wr_addr, exp_q[0].addr);
            check("stall_wr_data", wr_data, exp_q[0].data);
         end
         if (done_count > 0) finished = 1;
         tick();
      end
      start     = 1'b0;
      adc_valid = 1'b0;
      wr_grant  = 1'b0;
      if (!finished) begin
         checks++;
         fails++;
         $display("[TB] FAIL window_timeout: got %0d writes and no done, expected %0d writes", win_writes, NUM);
      end else begin
         check("first_addr", first_addr, 16'h0000);
         check("first_data", first_data, 30'h0080000);
         check("second_addr", second_addr, 16'h0001);
         check("second_data", second_data, 30'h00FFFF0);
         check("last_addr", last_addr, 16'h0EFF);
         check("total_writes", win_writes, NUM);
         check("done_after_last_grant", done_cyc - last_grant_cyc, 1);
         check("scoreboard_drained", exp_q.size(), 0);
         settle();
         check("busy_after_done", busy, 0);
         check("done_after_done", done, 0);
         repeat (3) tick();
         check("done_pulse_count", done_count, 1);
      end
   endtask

   initial begin
      #2;
      check_reset_outputs("reset");
      check("reset_wr_width", wr_width, DOUBLE_WIDTH);
      check("reset_wr_format", wr_format, INT_RES_DW_FX);
      #10;
      rst_n = 1'b1;
      tick();

      // Samples offered in IDLE are never accepted or written.
      adc_valid = 1'b1;
      adc_data  = 16'h1234;
      wr_grant  = 1'b1;
      repeat (5) begin
         settle();
         check("idle_adc_ready", adc_ready, 0);
         check("idle_wr_en", wr_en, 0);
         tick();
      end
      adc_valid = 1'b0;

      // Asynchronous reset after 100 accepted samples.
      clear_scoreboard();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 1000 && exp_idx < 100; n++) begin
         adc_valid = 1'b1;
         adc_data  = 16'(n + 256);
         settle();
         if (exp_idx < 100) tick();
      end
      check("reset_test_accepts", exp_idx, 100);
      rst_n     = 1'b0;
      adc_valid = 1'b0;
      wr_grant  = 1'b0;
      #1;
      check_reset_outputs("midload_reset");
      clear_scoreboard();
      tick();
      rst_n = 1'b1;

      run_window(100, 100, -1);
      run_window(100, 100, 500);

      // Abort after exactly 2000 writes with three samples buffered.
      clear_scoreboard();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         adc_valid = 1'b1;
         adc_data  = 16'($urandom);
         wr_grant  = (win_writes < 2000);
         settle();
         if (win_writes >= 2000 && exp_q.size() >= 3) break;
         tick();
      end
      check("abort_write_count", win_writes, 2000);
      check("abort_pending_addr", wr_addr, 16'd2000);
      check("abort_pending_wr_en", wr_en, 1);
      tick();
      adc_valid = 1'b0;
      wr_grant  = 1'b0;
      abort     = 1'b1;
      tick();
      abort = 1'b0;
      settle();
      check_reset_outputs("after_abort");
      clear_scoreboard();
      wr_grant = 1'b1;
      repeat (5) tick();
      check("abort_no_done", done_count, 0);
      check("abort_no_write", win_writes, 0);
      wr_grant = 1'b0;

      // abort beats start in the same cycle.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      settle();
      check("abort_start_busy", busy, 0);
      check("abort_start_adc_ready", adc_ready, 0);
      tick();

      run_window(50, 50, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
